// File: rtl/ascon_fifo_packer_if.sv
// Purpose : host-side handshake, control and FIFO write bus of the Ascon FIFO packer.
// Latency : n/a (signal bundle only).
// Backpressure: word_ready_o stalls the word source; fifo_full_i stalls the FIFO push.
// Ports   : start/abort/size control, busy/done/rem status, 32-bit word stream
//           (word_i/word_valid_i/word_ready_o), 64-bit FIFO write side
//           (fifo_flush_o/fifo_push_o/fifo_data_o/fifo_full_i).
//           The slave modport is the packer's view, the master modport the host's view.
interface ascon_fifo_packer_if #(
    parameter int DATA_AW = 7
);
    logic               start_i;
    logic               abort_i;
    logic [DATA_AW-1:0] size_i;
    logic               busy_o;
    logic               done_o;
    logic [31:0]        word_i;
    logic               word_valid_i;
    logic               word_ready_o;
    logic               fifo_flush_o;
    logic               fifo_push_o;
    logic [63:0]        fifo_data_o;
    logic               fifo_full_i;
    logic [DATA_AW-1:0] rem_o;

    modport slave (
        input  start_i, abort_i, size_i, word_i, word_valid_i, fifo_full_i,
        output busy_o, done_o, word_ready_o, fifo_flush_o, fifo_push_o, fifo_data_o, rem_o
    );

    modport master (
        output start_i, abort_i, size_i, word_i, word_valid_i, fifo_full_i,
        input  busy_o, done_o, word_ready_o, fifo_flush_o, fifo_push_o, fifo_data_o, rem_o
    );
endinterface

// File: rtl/ascon_fifo_packer.sv
// Purpose : packs a big-endian 32-bit word stream into zero-filled 64-bit entries for an Ascon AD/PT FIFO.
// Latency : start -> flush 1 cycle, then 3 cycles per entry (HI word, LO word, push); done 1 cycle after last push.
// Backpressure: words accepted only in HI/LO; a full FIFO holds the block in PUSH with data stable.
// Ports   : clk, rst (async, active-high) plus the slave side of ascon_fifo_packer_if.
module ascon_fifo_packer #(
    parameter int DATA_AW = 7
) (
    input  logic                clk,
    input  logic                rst,
    ascon_fifo_packer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_HI,
        S_LO,
        S_PUSH,
        S_DONE
    } state_t;

    state_t             state;
    logic [DATA_AW-1:0] rem;
    logic [63:0]        data;
    logic               flush;

    logic               in_word;
    logic [DATA_AW-1:0] take;
    logic [DATA_AW-1:0] rem_next;
    logic [31:0]        mask;
    logic [31:0]        masked;

    assign in_word  = (state == S_HI) || (state == S_LO);

    // Consume at most four bytes; the last word of a short message takes only what is left.
    assign take     = (rem < DATA_AW'(4)) ? rem : DATA_AW'(4);
    assign rem_next = rem - take;

    // Keep the upper rem bytes of a partial last word, zero the rest.
    always_comb begin
        mask = 32'hFFFF_FFFF;
        if (rem < DATA_AW'(4)) begin
            case (rem[1:0])
                2'd1:    mask = 32'hFF00_0000;
                2'd2:    mask = 32'hFFFF_0000;
                2'd3:    mask = 32'hFFFF_FF00;
                default: mask = 32'h0000_0000;
            endcase
        end
    end
    assign masked = bus.word_i & mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            rem   <= '0;
            data  <= '0;
            flush <= 1'b0;
        end else begin
            flush <= 1'b0;
            if ((state != S_IDLE) && bus.abort_i) begin
                // Abort discards the partial transfer and empties the FIFO.
                state <= S_IDLE;
                rem   <= '0;
                flush <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            rem   <= bus.size_i;
                            flush <= 1'b1;
                            state <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        state <= (rem == '0) ? S_DONE : S_HI;
                    end
                    S_HI: begin
                        if (bus.word_valid_i) begin
                            data  <= {masked, 32'h0000_0000};
                            rem   <= rem_next;
                            // An odd word count ends here: push without waiting for a low half.
                            state <= (rem_next == '0) ? S_PUSH : S_LO;
                        end
                    end
                    S_LO: begin
                        if (bus.word_valid_i) begin
                            data[31:0] <= masked;
                            rem        <= rem_next;
                            state      <= S_PUSH;
                        end
                    end
                    S_PUSH: begin
                        if (!bus.fifo_full_i) begin
                            state <= (rem == '0) ? S_DONE : S_HI;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o       = (state != S_IDLE);
    assign bus.done_o       = (state == S_DONE);
    assign bus.word_ready_o = in_word;
    assign bus.fifo_flush_o = flush;
    // Push fires in the same cycle the FIFO reports space.
    assign bus.fifo_push_o  = (state == S_PUSH) && !bus.fifo_full_i;
    assign bus.fifo_data_o  = data;
    assign bus.rem_o        = rem;

endmodule

// File: tb/tb_ascon_fifo_packer.sv
// Purpose : self-checking bench for ascon_fifo_packer with a byte-level reference model.
// Latency : n/a.
// Backpressure: randomised word_valid_i and fifo_full_i exercise both stall paths.
module tb_ascon_fifo_packer;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_fifo_packer_if #(.DATA_AW(AW)) bus ();

    ascon_fifo_packer #(.DATA_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] words_in[$];
    logic [31:0] src_q[$];
    logic [63:0] push_q[$];
    logic [63:0] exp_q[$];

    int flush_cnt, flush_cyc, push_cyc, consumed, done_cyc, rem_c1, rem_done, stall_cnt;
    int post_busy, post_ready, ab_flush, ab_busy, ab_rem, done_seen, rst_ok;
    bit timed_out, stall_ok;

    // Reference: message bytes laid out big-endian from the words, entries of 8 bytes, zero past size.
    function automatic void build_exp(input int size);
        int n;
        n = (size + 7) / 8;
        exp_q.delete();
        for (int e = 0; e < n; e++) begin
            logic [63:0] ent;
            ent = '0;
            for (int b = 0; b < 8; b++) begin
                int idx;
                logic [7:0] by;
                idx = e * 8 + b;
                by = 8'h00;
                if (idx < size) by = 8'(words_in[idx / 4] >> (8 * (3 - idx % 4)));
                ent = {ent[55:0], by};
            end
            exp_q.push_back(ent);
        end
    endfunction

    task automatic load_words(input int n);
        words_in.delete();
        src_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = $urandom;
            words_in.push_back(w);
            src_q.push_back(w);
        end
    endtask

    // Drives one transfer and records what the DUT did; comparisons live in the tests.
    task automatic run_xfer(input int size, input int vld_pct, input int full_pct, input int stall_len,
                            input int abort_at, input int rst_at, input bit start_abort);
        int ab_cyc;
        bit finished;
        bit stall_now;
        logic [63:0] stall_dat;
        flush_cnt = 0; flush_cyc = -1; push_cyc = -1; consumed = 0; done_cyc = -1;
        rem_c1 = -1; rem_done = -1; stall_cnt = 0; stall_ok = 1'b1; timed_out = 1'b0;
        ab_cyc = -1; ab_flush = -1; ab_busy = -1; ab_rem = -1; done_seen = 0; rst_ok = -1;
        finished = 1'b0; stall_dat = '0;
        push_q.delete();
        @(negedge clk);
        bus.start_i = 1'b1; bus.size_i = AW'(size); bus.abort_i = start_abort;
        bus.word_valid_i = 1'b0; bus.fifo_full_i = 1'b0;
        for (int k = 1; k <= 3000 && !finished; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            bus.size_i  = AW'($urandom);
            bus.abort_i = 1'b0;
            bus.word_valid_i = (src_q.size() > 0) && ($urandom_range(99) < vld_pct);
            bus.word_i = bus.word_valid_i ? src_q[0] : $urandom;
            bus.fifo_full_i = ($urandom_range(99) < full_pct);
            stall_now = 1'b0;
            if (stall_len > 0 && consumed >= 2 && push_q.size() == 0 && stall_cnt < stall_len) begin
                bus.fifo_full_i = 1'b1;
                stall_cnt++;
                stall_now = 1'b1;
            end
            if (abort_at >= 0 && ab_cyc < 0 && consumed == abort_at && k >= 2) begin
                bus.abort_i = 1'b1;
                ab_cyc = k;
            end
            if (rst_at >= 0 && consumed == rst_at && bus.word_ready_o) begin
                rst = 1'b1;
                #1;
                rst_ok = ({bus.busy_o, bus.done_o, bus.word_ready_o, bus.fifo_flush_o, bus.fifo_push_o} === 5'b0)
                      && (bus.fifo_data_o === 64'h0) && (bus.rem_o === '0);
                #1 rst = 1'b0;
                finished = 1'b1;
            end else begin
                #1;
                if (k == 1) rem_c1 = int'(bus.rem_o);
                if (stall_now) begin
                    if (stall_cnt == 1) stall_dat = bus.fifo_data_o;
                    else if (bus.fifo_data_o !== stall_dat) stall_ok = 1'b0;
                    if (bus.fifo_push_o !== 1'b0) stall_ok = 1'b0;
                end
                if (bus.fifo_flush_o) begin flush_cnt++; flush_cyc = k; end
                if (bus.fifo_push_o) begin
                    push_q.push_back(bus.fifo_data_o);
                    if (push_cyc < 0) push_cyc = k;
                end
                if (bus.word_ready_o && bus.word_valid_i && !bus.abort_i) begin
                    void'(src_q.pop_front());
                    consumed++;
                end
                if (bus.done_o) begin
                    done_seen = 1; done_cyc = k; rem_done = int'(bus.rem_o); finished = 1'b1;
                end
                if (ab_cyc > 0 && k == ab_cyc + 1) begin
                    ab_flush = int'(bus.fifo_flush_o); ab_busy = int'(bus.busy_o);
                    ab_rem = int'(bus.rem_o); finished = 1'b1;
                end
            end
        end
        if (!finished) timed_out = 1'b1;
        // One extra cycle: offer a spare word and look for stray activity.
        @(negedge clk);
        bus.abort_i = 1'b0; bus.fifo_full_i = 1'b0;
        bus.word_valid_i = (src_q.size() > 0);
        if (bus.word_valid_i) bus.word_i = src_q[0];
        #1;
        post_busy = int'(bus.busy_o);
        post_ready = int'(bus.word_ready_o);
        if (bus.done_o) done_seen = 1;
        if (bus.fifo_push_o) push_q.push_back(bus.fifo_data_o);
        @(negedge clk);
        bus.word_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.size_i = '0; bus.word_i = '0;
        bus.word_valid_i = 1'b0; bus.fifo_full_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if ({bus.busy_o, bus.done_o, bus.word_ready_o, bus.fifo_flush_o, bus.fifo_push_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl got=%b exp=00000", {bus.busy_o, bus.done_o, bus.word_ready_o, bus.fifo_flush_o, bus.fifo_push_o}); end
        n_tests++; if (bus.fifo_data_o !== 64'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.fifo_data_o); end
        n_tests++; if (bus.rem_o !== '0) begin n_fail++; $display("FAIL reset_rem got=%0d exp=0", bus.rem_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_size8();
        words_in = '{32'h0001_0203, 32'h0405_0607};
        src_q = words_in;
        run_xfer(8, 100, 0, 0, -1, -1, 1'b0);
        n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL s8_timeout got=1 exp=0"); end
        n_tests++; if (flush_cnt !== 1 || flush_cyc !== 1) begin n_fail++; $display("FAIL s8_flush got=%0d@%0d exp=1@1", flush_cnt, flush_cyc); end
        n_tests++; if (rem_c1 !== 8) begin n_fail++; $display("FAIL s8_rem_latch got=%0d exp=8", rem_c1); end
        n_tests++; if (push_q.size() !== 1 || push_cyc !== 4) begin n_fail++; $display("FAIL s8_push_cnt got=%0d@%0d exp=1@4", push_q.size(), push_cyc); end
        n_tests++; if (push_q.size() != 1 || push_q[0] !== 64'h0001_0203_0405_0607) begin n_fail++; $display("FAIL s8_data got=%h exp=0001020304050607", push_q.size() > 0 ? push_q[0] : 64'h0); end
        n_tests++; if (done_cyc !== 5 || rem_done !== 0) begin n_fail++; $display("FAIL s8_done got=cyc%0d rem%0d exp=cyc5 rem0", done_cyc, rem_done); end
        n_tests++; if (post_busy !== 0) begin n_fail++; $display("FAIL s8_busy_after got=%0d exp=0", post_busy); end
    endtask

    task automatic test_size5();
        words_in = '{32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4};
        src_q = words_in;
        run_xfer(5, 100, 0, 0, -1, -1, 1'b1);
        n_tests++; if (push_q.size() != 1 || push_q[0] !== 64'hA1A2_A3A4_B100_0000) begin n_fail++; $display("FAIL s5_data got=%h exp=A1A2A3A4B1000000", push_q.size() > 0 ? push_q[0] : 64'h0); end
        n_tests++; if (consumed !== 2 || post_ready !== 0) begin n_fail++; $display("FAIL s5_words got=%0d ready=%0d exp=2 ready=0", consumed, post_ready); end
    endtask

    task automatic test_size12();
        load_words(4);
        run_xfer(12, 100, 0, 0, -1, -1, 1'b0);
        n_tests++; if (push_q.size() !== 2) begin n_fail++; $display("FAIL s12_push_cnt got=%0d exp=2", push_q.size()); end
        n_tests++; if (push_q.size() != 2 || push_q[0] !== {words_in[0], words_in[1]} || push_q[1] !== {words_in[2], 32'h0}) begin
            n_fail++; $display("FAIL s12_data got=%h/%h exp=%h/%h", push_q.size() > 0 ? push_q[0] : 64'h0,
                push_q.size() > 1 ? push_q[1] : 64'h0, {words_in[0], words_in[1]}, {words_in[2], 32'h0}); end
        n_tests++; if (consumed !== 3 || post_ready !== 0) begin n_fail++; $display("FAIL s12_words got=%0d ready=%0d exp=3 ready=0", consumed, post_ready); end
    endtask

    task automatic test_size0();
        load_words(1);
        run_xfer(0, 100, 0, 0, -1, -1, 1'b0);
        n_tests++; if (flush_cnt !== 1 || push_q.size() !== 0) begin n_fail++; $display("FAIL s0_flush_push got=%0d/%0d exp=1/0", flush_cnt, push_q.size()); end
        n_tests++; if (done_cyc !== 2 || consumed !== 0) begin n_fail++; $display("FAIL s0_done got=cyc%0d words%0d exp=cyc2 words0", done_cyc, consumed); end
    endtask

    task automatic test_stall();
        load_words(4);
        build_exp(16);
        run_xfer(16, 50, 0, 10, -1, -1, 1'b0);
        n_tests++; if (stall_cnt !== 10 || stall_ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold got=%0d ok=%0d exp=10 ok=1", stall_cnt, stall_ok); end
        n_tests++; if (push_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", push_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < push_q.size(); i++) begin
            n_tests++; if (push_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, push_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        load_words(4);
        run_xfer(16, 100, 0, 0, 1, -1, 1'b0);
        n_tests++; if (ab_flush !== 1 || ab_busy !== 0 || ab_rem !== 0) begin n_fail++; $display("FAIL abort_next got=flush%0d busy%0d rem%0d exp=flush1 busy0 rem0", ab_flush, ab_busy, ab_rem); end
        n_tests++; if (push_q.size() !== 0 || done_seen !== 0 || consumed !== 1) begin n_fail++; $display("FAIL abort_side got=push%0d done%0d words%0d exp=push0 done0 words1", push_q.size(), done_seen, consumed); end
    endtask

    task automatic test_reset_mid();
        load_words(4);
        run_xfer(16, 100, 0, 0, -1, 2, 1'b0);
        n_tests++; if (rst_ok !== 1) begin n_fail++; $display("FAIL rst_mid got=%0d exp=1", rst_ok); end
        n_tests++; if (push_q.size() !== 1 || post_busy !== 0 || done_seen !== 0) begin n_fail++; $display("FAIL rst_after got=push%0d busy%0d done%0d exp=push1 busy0 done0", push_q.size(), post_busy, done_seen); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int size;
            size = (it == 0) ? 127 : int'($urandom_range(127));
            load_words((size + 3) / 4 + 1);
            build_exp(size);
            run_xfer(size, int'($urandom_range(100, 30)), int'($urandom_range(50)), 0, -1, -1, it[0]);
            n_tests++; if (push_q.size() !== exp_q.size() || consumed !== (size + 3) / 4 || done_seen !== 1) begin
                n_fail++; $display("FAIL rnd%0d_counts size=%0d got=push%0d words%0d done%0d exp=push%0d words%0d done1",
                    it, size, push_q.size(), consumed, done_seen, exp_q.size(), (size + 3) / 4); end
            for (int i = 0; i < exp_q.size() && i < push_q.size(); i++) begin
                n_tests++; if (push_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", it, i, push_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_size8();
        test_size5();
        test_size12();
        test_size0();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
